me_lsu: RTL
===========

# me_lsu

Parametrised memory-stage load/store unit with a variable-latency data-memory handshake, replacing the fixed single-cycle memory stage register. It sits between execute and writeback. It accepts one instruction at a time from execute and issues at most one data-memory transaction for it. It aligns and sign- or zero-extends load data by byte lane and presents a registered writeback result under a valid/ready handshake.

## Interface
- WORD_W, 32: datapath width; 32 or 64. NB = WORD_W/8 byte lanes; LB = log2(NB).
- ADDR_W, 32: address / PC width.
- INSTR_W, 32: instruction width.
- REG_IDX_W, 5: destination register index width.
- DEST_SRC_W, 2: width of `DEST_SRC_*` codes (NONE, ALU, MEM).
- MEM_OP_W, 4: width of `MEM_OP_*` codes (NONE, RD_BYTE, RD_UBYTE, RD_HALF, RD_UHALF, RD_WORD, WR_BYTE, WR_HALF, WR_WORD).
- clk  in  1  clock, all state on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the held or in-flight instruction.
- i_valid / o_ready  in / out  1  upstream handshake; accept when both are high.
- i_pc, i_instr  in  ADDR_W, INSTR_W  carried through unchanged.
- i_dest_src, i_dest_reg  in  DEST_SRC_W, REG_IDX_W  writeback control.
- i_alu_eval  in  WORD_W  ALU result; used as the byte address for memory ops.
- i_store_data  in  WORD_W  store operand; low bytes are used.
- i_mem_op  in  MEM_OP_W  memory operation.
- o_mem_req, o_mem_we  out  1  request; write enable.
- o_mem_addr  out  ADDR_W  address with low LB bits forced to 0.
- o_mem_wdata  out  WORD_W  store data replicated across lanes.
- o_mem_be  out  NB  byte enables.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid, i_mem_rdata  in  1, WORD_W  read response; for reads only, at least 1 cycle after gnt.
- o_valid / i_ready  out / in  1  downstream handshake.
- o_pc, o_instr, o_dest_src, o_dest_reg, o_dest_data  out  registered writeback bundle.
- o_misaligned  out  1  the held result is a misaligned access.

## Operation
- States: IDLE, REQ, WAIT, plus an output register with a valid flag.
- o_ready = (state==IDLE) && (!o_valid || i_ready) && !flush.
- **On accept**, capture every input. Then:
  - ALU/NONE op: load the output register directly; o_dest_data = i_alu_eval if dest_src==ALU, otherwise 0.
  - Misaligned op (half with addr[0]=1; word with addr[LB-1:0]≠0): no bus request; o_misaligned=1, o_dest_src=NONE, o_dest_data=0.
  - Aligned memory op: go to REQ.
- **REQ**: hold o_mem_req=1 and all bus outputs stable until i_mem_gnt.
  - Store granted: load the output register (dest_src NONE, data 0) and go to IDLE.
  - Read granted: go to WAIT.
- **WAIT**: on i_mem_rvalid, go to IDLE and load the output register:
  - byte lane = addr[LB-1:0] (little-endian); half uses lanes addr and addr+1.
  - RD_BYTE / RD_HALF: sign-extend from bit 7 / 15.
  - RD_UBYTE / RD_UHALF: zero-extend.
  - RD_WORD: full WORD_W, no extension.
- **Byte enables**: byte → one bit at the lane; half → two bits; word → all NB bits.
- **Output register**: o_valid clears on (o_valid && i_ready) unless a new result loads in the same cycle; loading and draining in the same cycle is legal.
- **flush**:
  - Clears o_valid next edge.
  - In REQ or WAIT, marks the instruction killed. The bus transaction still completes (a REQ is never dropped; rvalid is still consumed), but it produces no o_valid.
  - flush and accept in the same cycle: no accept (o_ready low).

## Timing
- Reset, asynchronous on clr_n=0:
  - state IDLE, kill flag 0.
  - o_valid, o_mem_req, o_mem_we, o_misaligned = 0.
  - All data/address/be/pc/instr/dest outputs = 0.
  - o_ready = 1 once clr_n is high.
- Reset mid-transaction aborts immediately; the memory side is reset together with this unit.
- ALU op or misaligned op accepted at edge N: o_valid from N+1.
- Load accepted at N: o_mem_req from N+1; gnt at G ≥ N+1; rvalid at R ≥ G+1; o_valid from R+1.
- Store: o_valid from G+1.
- Throughput: one instruction per cycle for back-to-back ALU ops with i_ready held high.

## Test plan
- Reset with clr_n=0 asserted between edges: all outputs are 0 immediately; after release o_ready=1.
- RD_BYTE, addr 0x1003, rdata 0x80FF_1234 → be=4'b1000, o_mem_addr=0x1000, o_dest_data=0xFFFF_FF80. Same stimulus with RD_UBYTE → 0x0000_0080.
- RD_HALF, addr 0x2, rdata 0x8001_0000, gnt delayed 3 cycles, rvalid 2 cycles after gnt → o_mem_req held 4 cycles, o_dest_data=0xFFFF_8001, o_valid 1 cycle after rvalid.
- WR_HALF, addr 0x6, store 0x0000_BEEF → o_mem_be=4'b1100, o_mem_wdata=0xBEEF_BEEF, o_mem_we=1, o_valid with dest_src NONE.
- RD_WORD at addr 0x5 → no o_mem_req, next cycle o_valid=1, o_misaligned=1, o_dest_data=0.
- Load in WAIT, flush pulsed, rvalid arrives 2 cycles later → o_valid never asserts, returns to IDLE, next ALU op 0x42 emerges with o_dest_data=0x42. Also: i_ready low for 3 cycles → output held, o_ready low.

Source files
------------

// File: rtl/me_lsu.sv
// Memory-stage load/store unit: one instruction at a time, variable-latency
// data-memory handshake, load alignment/extension and a registered writeback result.
module me_lsu #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned REG_IDX_W  = 5,
  parameter int unsigned DEST_SRC_W = 2,
  parameter int unsigned MEM_OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic [WORD_W-1:0]     i_store_data,
  input  logic [MEM_OP_W-1:0]   i_mem_op,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [WORD_W-1:0]     o_mem_wdata,
  output logic [WORD_W/8-1:0]   o_mem_be,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [WORD_W-1:0]     i_mem_rdata,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic [WORD_W-1:0]     o_dest_data,
  output logic                  o_misaligned
);

  localparam int unsigned NB = WORD_W / 8;
  localparam int unsigned NH = NB / 2;
  localparam int unsigned LB = $clog2(NB);

  localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = DEST_SRC_W'(0);
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU  = DEST_SRC_W'(1);

  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_BYTE  = MEM_OP_W'(1);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UBYTE = MEM_OP_W'(2);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_HALF  = MEM_OP_W'(3);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UHALF = MEM_OP_W'(4);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_WORD  = MEM_OP_W'(5);
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_BYTE  = MEM_OP_W'(6);
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_HALF  = MEM_OP_W'(7);
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_WORD  = MEM_OP_W'(8);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic                  kill_q, kill_d;
  logic                  wr_q, wr_d;
  logic [MEM_OP_W-1:0]   op_q, op_d;
  logic [LB-1:0]         lane_q, lane_d;
  logic [DEST_SRC_W-1:0] src_q, src_d;
  logic [REG_IDX_W-1:0]  reg_q, reg_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]    instr_q, instr_d;

  logic                  valid_d, mis_d, req_d, we_d;
  logic [ADDR_W-1:0]     out_pc_d, addr_d;
  logic [INSTR_W-1:0]    out_instr_d;
  logic [DEST_SRC_W-1:0] out_src_d;
  logic [REG_IDX_W-1:0]  out_reg_d;
  logic [WORD_W-1:0]     out_data_d, wdata_d;
  logic [NB-1:0]         be_d;

  logic                  accept;
  logic                  in_rd, in_wr, in_mis;
  logic [LB-1:0]         in_lane;
  logic [NB-1:0]         in_be;
  logic [WORD_W-1:0]     in_wdata;
  logic [ADDR_W-1:0]     in_addr;
  logic [WORD_W-1:0]     rd_shift, ld_data;

  logic                  ld, ld_from_in, ld_mis;
  logic [DEST_SRC_W-1:0] ld_src;
  logic [WORD_W-1:0]     ld_wdata;

  assign o_ready = (state_q == S_IDLE) && (!o_valid || i_ready) && !flush;
  assign accept  = i_valid && o_ready;
  assign rd_shift = i_mem_rdata >> {lane_q, 3'b000};

  // Decode the incoming op: direction, alignment, lane enables, replicated store data
  always_comb begin
    in_rd    = 1'b0;
    in_wr    = 1'b0;
    in_mis   = 1'b0;
    in_lane  = i_alu_eval[LB-1:0];
    in_be    = '0;
    in_wdata = '0;
    in_addr  = ADDR_W'(i_alu_eval);
    in_addr[LB-1:0] = '0;
    case (i_mem_op)
      MEM_OP_RD_BYTE, MEM_OP_RD_UBYTE: begin
        in_rd = 1'b1;
        in_be = NB'(1) << in_lane;
      end
      MEM_OP_RD_HALF, MEM_OP_RD_UHALF: begin
        in_rd  = 1'b1;
        in_mis = in_lane[0];
        in_be  = NB'(3) << in_lane;
      end
      MEM_OP_RD_WORD: begin
        in_rd  = 1'b1;
        in_mis = |in_lane;
        in_be  = '1;
      end
      MEM_OP_WR_BYTE: begin
        in_wr    = 1'b1;
        in_be    = NB'(1) << in_lane;
        in_wdata = {NB{i_store_data[7:0]}};
      end
      MEM_OP_WR_HALF: begin
        in_wr    = 1'b1;
        in_mis   = in_lane[0];
        in_be    = NB'(3) << in_lane;
        in_wdata = {NH{i_store_data[15:0]}};
      end
      MEM_OP_WR_WORD: begin
        in_wr    = 1'b1;
        in_mis   = |in_lane;
        in_be    = '1;
        in_wdata = i_store_data;
      end
      default: ;
    endcase
  end

  // Align the returned word to the captured lane and extend
  always_comb begin
    case (op_q)
      MEM_OP_RD_BYTE:  ld_data = WORD_W'($signed(rd_shift[7:0]));
      MEM_OP_RD_UBYTE: ld_data = WORD_W'(rd_shift[7:0]);
      MEM_OP_RD_HALF:  ld_data = WORD_W'($signed(rd_shift[15:0]));
      MEM_OP_RD_UHALF: ld_data = WORD_W'(rd_shift[15:0]);
      default:         ld_data = rd_shift;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    wr_d        = wr_q;
    op_d        = op_q;
    lane_d      = lane_q;
    src_d       = src_q;
    reg_d       = reg_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    req_d       = o_mem_req;
    we_d        = o_mem_we;
    addr_d      = o_mem_addr;
    wdata_d     = o_mem_wdata;
    be_d        = o_mem_be;
    valid_d     = o_valid && !i_ready;
    mis_d       = o_misaligned;
    out_pc_d    = o_pc;
    out_instr_d = o_instr;
    out_src_d   = o_dest_src;
    out_reg_d   = o_dest_reg;
    out_data_d  = o_dest_data;
    ld          = 1'b0;
    ld_from_in  = 1'b0;
    ld_mis      = 1'b0;
    ld_src      = DEST_SRC_NONE;
    ld_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = in_wr;
          op_d    = i_mem_op;
          lane_d  = in_lane;
          src_d   = i_dest_src;
          reg_d   = i_dest_reg;
          pc_d    = i_pc;
          instr_d = i_instr;
          if (!in_rd && !in_wr) begin
            ld         = 1'b1;
            ld_from_in = 1'b1;
            ld_src     = i_dest_src;
            ld_wdata   = (i_dest_src == DEST_SRC_ALU) ? i_alu_eval : '0;
          end else if (in_mis) begin
            ld         = 1'b1;
            ld_from_in = 1'b1;
            ld_mis     = 1'b1;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = in_wr;
            addr_d  = in_addr;
            wdata_d = in_wdata;
            be_d    = in_be;
          end
        end
      end
      S_REQ: begin
        if (flush) kill_d = 1'b1;
        if (i_mem_gnt) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (wr_q) begin
            state_d = S_IDLE;
            kill_d  = 1'b0;
            ld      = !(kill_q || flush);
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (i_mem_rvalid) begin
          state_d  = S_IDLE;
          kill_d   = 1'b0;
          ld       = !(kill_q || flush);
          ld_src   = src_q;
          ld_wdata = ld_data;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ld) begin
      valid_d     = 1'b1;
      mis_d       = ld_mis;
      out_src_d   = ld_src;
      out_data_d  = ld_wdata;
      out_pc_d    = ld_from_in ? i_pc : pc_q;
      out_instr_d = ld_from_in ? i_instr : instr_q;
      out_reg_d   = ld_from_in ? i_dest_reg : reg_q;
    end
    if (flush) valid_d = 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      kill_q       <= 1'b0;
      wr_q         <= 1'b0;
      op_q         <= '0;
      lane_q       <= '0;
      src_q        <= '0;
      reg_q        <= '0;
      pc_q         <= '0;
      instr_q      <= '0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_be     <= '0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
      o_pc         <= '0;
      o_instr      <= '0;
      o_dest_src   <= '0;
      o_dest_reg   <= '0;
      o_dest_data  <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      wr_q         <= wr_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      src_q        <= src_d;
      reg_q        <= reg_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      o_mem_req    <= req_d;
      o_mem_we     <= we_d;
      o_mem_addr   <= addr_d;
      o_mem_wdata  <= wdata_d;
      o_mem_be     <= be_d;
      o_valid      <= valid_d;
      o_misaligned <= mis_d;
      o_pc         <= out_pc_d;
      o_instr      <= out_instr_d;
      o_dest_src   <= out_src_d;
      o_dest_reg   <= out_reg_d;
      o_dest_data  <= out_data_d;
    end
  end

endmodule
